// File: rtl/sram_bus_arbiter_n.sv
// N-channel arbiter that funnels per-channel read/write line requests onto a single
// SRAM-side read port and write port, with one transaction outstanding at a time.
module sram_bus_arbiter_n #(
    parameter int NUM_CH   = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 256,
    parameter int TYPE_W   = 6,
    parameter int STRB_W   = 16,
    parameter int WR_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        up_r_req,
    input  logic [NUM_CH*ADDR_W-1:0] up_r_addr,
    input  logic [NUM_CH*TYPE_W-1:0] up_r_type,
    output logic [NUM_CH-1:0]        up_r_rdy,
    output logic [DATA_W-1:0]        up_re_data,
    output logic [NUM_CH-1:0]        up_re_valid,
    input  logic [NUM_CH-1:0]        up_w_req,
    input  logic [NUM_CH*ADDR_W-1:0] up_w_addr,
    input  logic [NUM_CH*DATA_W-1:0] up_w_data,
    input  logic [NUM_CH*TYPE_W-1:0] up_w_type,
    input  logic [NUM_CH*STRB_W-1:0] up_w_strb,
    output logic [NUM_CH-1:0]        up_w_rdy,
    output logic                     dn_r_req,
    output logic [ADDR_W-1:0]        dn_r_addr,
    output logic [TYPE_W-1:0]        dn_r_type,
    input  logic                     dn_r_rdy,
    input  logic [DATA_W-1:0]        dn_re_data,
    input  logic                     dn_re_valid,
    output logic                     dn_w_req,
    output logic [ADDR_W-1:0]        dn_w_addr,
    output logic [DATA_W-1:0]        dn_w_data,
    output logic [TYPE_W-1:0]        dn_w_type,
    output logic [STRB_W-1:0]        dn_w_strb,
    input  logic                     dn_w_rdy,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, g_q, g_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [TYPE_W-1:0]  type_q, type_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [STRB_W-1:0]  strb_q, strb_d;
    logic [IDX_W-1:0]   rsel, wsel;
    logic               pick_wr;

    // First requesting channel at or after ptr, wrapping modulo NUM_CH.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                 input logic [IDX_W-1:0]  ptr);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = IDX_W'(idx);
            end
        end
        return sel;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
        return (g == IDX_W'(NUM_CH - 1)) ? '0 : g + IDX_W'(1);
    endfunction

    assign rsel    = rr_pick(up_r_req, rd_ptr_q);
    assign wsel    = rr_pick(up_w_req, wr_ptr_q);
    assign pick_wr = (|up_w_req) && ((WR_FIRST != 0) || !(|up_r_req));

    assign dn_r_addr = addr_q;
    assign dn_r_type = type_q;
    assign dn_w_addr = addr_q;
    assign dn_w_type = type_q;
    assign dn_w_data = data_q;
    assign dn_w_strb = strb_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        g_d         = g_q;
        addr_d      = addr_q;
        type_d      = type_q;
        data_d      = data_q;
        strb_d      = strb_q;
        up_r_rdy    = '0;
        up_w_rdy    = '0;
        up_re_valid = '0;
        up_re_data  = '0;
        dn_r_req    = 1'b0;
        dn_w_req    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_wr) begin
                    g_d     = wsel;
                    addr_d  = up_w_addr[wsel*ADDR_W +: ADDR_W];
                    type_d  = up_w_type[wsel*TYPE_W +: TYPE_W];
                    data_d  = up_w_data[wsel*DATA_W +: DATA_W];
                    strb_d  = up_w_strb[wsel*STRB_W +: STRB_W];
                    state_d = WR;
                end else if (|up_r_req) begin
                    g_d     = rsel;
                    addr_d  = up_r_addr[rsel*ADDR_W +: ADDR_W];
                    type_d  = up_r_type[rsel*TYPE_W +: TYPE_W];
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                dn_r_req = 1'b1;
                // An accept in the same cycle as a dropped request still wins.
                if (dn_r_rdy) begin
                    up_r_rdy[g_q] = 1'b1;
                    state_d       = RD_DATA;
                end else if (!up_r_req[g_q]) begin
                    state_d = IDLE;
                end
            end
            RD_DATA: begin
                if (dn_re_valid) begin
                    up_re_valid[g_q] = 1'b1;
                    up_re_data       = dn_re_data;
                    rd_ptr_d         = next_ptr(g_q);
                    state_d          = IDLE;
                end
            end
            WR: begin
                dn_w_req = 1'b1;
                if (dn_w_rdy) begin
                    up_w_rdy[g_q] = 1'b1;
                    wr_ptr_d      = next_ptr(g_q);
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            g_q      <= '0;
            addr_q   <= '0;
            type_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            g_q      <= g_d;
            addr_q   <= addr_d;
            type_q   <= type_d;
            data_q   <= data_d;
            strb_q   <= strb_d;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter_n.sv
// Directed bench for sram_bus_arbiter_n: vector table on a 4-channel write-first
// instance, plus short sequences on a read-first and an 8-channel instance.
module tb_sram_bus_arbiter_n;

    localparam int AW = 32, DW = 256, TW = 6, SW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main instance (4 ch, writes first) and shared upstream fields
    logic [3:0]      r_req, w_req, r_rdy, w_rdy, re_valid;
    logic [4*AW-1:0] r_addr, w_addr;
    logic [4*DW-1:0] w_data;
    logic [4*TW-1:0] r_type, w_type;
    logic [4*SW-1:0] w_strb;
    logic [DW-1:0]   re_data, dn_re_data, dn_w_data;
    logic            dn_r_req, dn_r_rdy, dn_re_valid, dn_w_req, dn_w_rdy, busy;
    logic [AW-1:0]   dn_r_addr, dn_w_addr;
    logic [TW-1:0]   dn_r_type, dn_w_type;
    logic [SW-1:0]   dn_w_strb;

    // read-first instance
    logic [3:0]      r_req_b, w_req_b, r_rdy_b, w_rdy_b, re_valid_b;
    logic [DW-1:0]   re_data_b, dn_w_data_b;
    logic            dn_r_req_b, dn_r_rdy_b, dn_re_valid_b, dn_w_req_b, dn_w_rdy_b, busy_b;
    logic [AW-1:0]   dn_r_addr_b, dn_w_addr_b;
    logic [TW-1:0]   dn_r_type_b, dn_w_type_b;
    logic [SW-1:0]   dn_w_strb_b;

    // 8-channel write-only instance
    logic [7:0]      w_req_c, r_rdy_c, w_rdy_c, re_valid_c;
    logic [8*32-1:0] w_addr_c, w_data_c;
    logic [8*TW-1:0] w_type_c;
    logic [8*SW-1:0] w_strb_c;
    logic [31:0]     re_data_c, dn_w_data_c, dn_r_addr_c, dn_w_addr_c;
    logic            dn_r_req_c, dn_w_req_c, dn_w_rdy_c, busy_c;
    logic [TW-1:0]   dn_r_type_c, dn_w_type_c;
    logic [SW-1:0]   dn_w_strb_c;

    sram_bus_arbiter_n #(.NUM_CH(4), .WR_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_r_req(r_req), .up_r_addr(r_addr), .up_r_type(r_type), .up_r_rdy(r_rdy),
        .up_re_data(re_data), .up_re_valid(re_valid),
        .up_w_req(w_req), .up_w_addr(w_addr), .up_w_data(w_data), .up_w_type(w_type),
        .up_w_strb(w_strb), .up_w_rdy(w_rdy),
        .dn_r_req(dn_r_req), .dn_r_addr(dn_r_addr), .dn_r_type(dn_r_type), .dn_r_rdy(dn_r_rdy),
        .dn_re_data(dn_re_data), .dn_re_valid(dn_re_valid),
        .dn_w_req(dn_w_req), .dn_w_addr(dn_w_addr), .dn_w_data(dn_w_data), .dn_w_type(dn_w_type),
        .dn_w_strb(dn_w_strb), .dn_w_rdy(dn_w_rdy), .busy(busy));

    sram_bus_arbiter_n #(.NUM_CH(4), .WR_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .up_r_req(r_req_b), .up_r_addr(r_addr), .up_r_type(r_type), .up_r_rdy(r_rdy_b),
        .up_re_data(re_data_b), .up_re_valid(re_valid_b),
        .up_w_req(w_req_b), .up_w_addr(w_addr), .up_w_data(w_data), .up_w_type(w_type),
        .up_w_strb(w_strb), .up_w_rdy(w_rdy_b),
        .dn_r_req(dn_r_req_b), .dn_r_addr(dn_r_addr_b), .dn_r_type(dn_r_type_b), .dn_r_rdy(dn_r_rdy_b),
        .dn_re_data(dn_re_data), .dn_re_valid(dn_re_valid_b),
        .dn_w_req(dn_w_req_b), .dn_w_addr(dn_w_addr_b), .dn_w_data(dn_w_data_b), .dn_w_type(dn_w_type_b),
        .dn_w_strb(dn_w_strb_b), .dn_w_rdy(dn_w_rdy_b), .busy(busy_b));

    sram_bus_arbiter_n #(.NUM_CH(8), .DATA_W(32)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .up_r_req(8'h00), .up_r_addr('0), .up_r_type('0), .up_r_rdy(r_rdy_c),
        .up_re_data(re_data_c), .up_re_valid(re_valid_c),
        .up_w_req(w_req_c), .up_w_addr(w_addr_c), .up_w_data(w_data_c), .up_w_type(w_type_c),
        .up_w_strb(w_strb_c), .up_w_rdy(w_rdy_c),
        .dn_r_req(dn_r_req_c), .dn_r_addr(dn_r_addr_c), .dn_r_type(dn_r_type_c), .dn_r_rdy(1'b0),
        .dn_re_data(32'h0), .dn_re_valid(1'b0),
        .dn_w_req(dn_w_req_c), .dn_w_addr(dn_w_addr_c), .dn_w_data(dn_w_data_c), .dn_w_type(dn_w_type_c),
        .dn_w_strb(dn_w_strb_c), .dn_w_rdy(dn_w_rdy_c), .busy(busy_c));

    typedef struct {
        logic [3:0] rreq, wreq;
        logic       rrdy, rev, wrdy;
        logic       busy, dnr, dnw;
        int         ch;
        logic [3:0] urrdy, uwrdy, urev;
    } vec_t;

    vec_t tbl[$];
    int   nerr = 0;
    int   nchk = 0;

    function automatic vec_t mk(input logic [3:0] rreq, input logic [3:0] wreq,
                                input logic rrdy, input logic rev, input logic wrdy,
                                input logic bsy, input logic dnr, input logic dnw, input int ch,
                                input logic [3:0] urrdy, input logic [3:0] uwrdy,
                                input logic [3:0] urev);
        vec_t v;
        v.rreq = rreq; v.wreq = wreq; v.rrdy = rrdy; v.rev = rev; v.wrdy = wrdy;
        v.busy = bsy; v.dnr = dnr; v.dnw = dnw; v.ch = ch;
        v.urrdy = urrdy; v.uwrdy = uwrdy; v.urev = urev;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        r_req = '0; w_req = '0; dn_r_rdy = 0; dn_re_valid = 0; dn_w_rdy = 0;
        r_req_b = '0; w_req_b = '0; dn_r_rdy_b = 0; dn_re_valid_b = 0; dn_w_rdy_b = 0;
        w_req_c = '0; dn_w_rdy_c = 0;
        dn_re_data = {32{8'hA5}};
        for (int i = 0; i < 4; i++) begin
            r_addr[i*AW +: AW] = (i == 2) ? 32'h8000_0040 : 32'h1000_0000 + i;
            r_type[i*TW +: TW] = TW'(i + 1);
            w_addr[i*AW +: AW] = 32'h2000_0000 + i;
            w_type[i*TW +: TW] = TW'(i + 8);
            w_strb[i*SW +: SW] = 16'hF000 + 16'(i);
            w_data[i*DW +: DW] = {8{32'hD000_0000 + i}};
        end
        for (int i = 0; i < 8; i++) begin
            w_addr_c[i*32 +: 32] = 32'h3000_0000 + i;
            w_data_c[i*32 +: 32] = 32'hC000_0000 + i;
            w_type_c[i*TW +: TW] = TW'(i);
            w_strb_c[i*SW +: SW] = 16'(i);
        end

        // single read on ch2
        tbl.push_back(mk(4'b0100, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0100, 4'b0000, 0, 0, 0, 1, 1, 0, 2, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0100, 4'b0000, 1, 0, 0, 1, 1, 0, 2, 4'b0100, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0100));
        // all four held with immediate downstream; read ptr is 3 here
        for (int k = 0; k < 5; k++) begin
            int c;
            c = (3 + k) % 4;
            tbl.push_back(mk(4'b1111, 4'b0000, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
            tbl.push_back(mk(4'b1111, 4'b0000, 1, 1, 0, 1, 1, 0, c, 4'(1 << c), 4'b0000, 4'b0000));
            tbl.push_back(mk(4'b1111, 4'b0000, 1, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'(1 << c)));
        end
        // aborts of ch3 then ch1; read ptr must stay 0
        tbl.push_back(mk(4'b1000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b1000, 4'b0000, 0, 0, 0, 1, 1, 0, 3, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 1, 1, 0, 3, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b0000, 0, 0, 0, 1, 1, 0, 1, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 1, 1, 0, 1, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0101, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0101, 4'b0000, 1, 0, 0, 1, 1, 0, 0, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0100, 4'b0000, 0, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0001));
        tbl.push_back(mk(4'b0100, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0100, 4'b0000, 1, 0, 0, 1, 1, 0, 2, 4'b0100, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0100));
        // ch1 write and ch0 read together: write first
        tbl.push_back(mk(4'b0001, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0010, 0, 0, 0, 1, 0, 1, 1, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0010, 0, 0, 1, 1, 0, 1, 1, 4'b0000, 4'b0010, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 1, 0, 0, 1, 1, 0, 0, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0001));
        tbl.push_back(mk(4'b0000, 4'b0000, 0, 1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));

        // outputs during reset
        r_req = 4'b1111; dn_re_valid = 1; dn_w_rdy = 1;
        #2;
        chk("rst busy", busy, 0);
        chk("rst dn_r_req", dn_r_req, 0);
        chk("rst dn_w_req", dn_w_req, 0);
        chk("rst up pulses", {r_rdy, w_rdy, re_valid}, 0);
        chk("rst re_data", re_data, 0);
        r_req = '0; dn_re_valid = 0; dn_w_rdy = 0;
        #10 rst_n = 1'b1;
        step();

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            r_req = v.rreq; w_req = v.wreq;
            dn_r_rdy = v.rrdy; dn_re_valid = v.rev; dn_w_rdy = v.wrdy;
            #1;
            chk($sformatf("row%0d busy", i), busy, v.busy);
            chk($sformatf("row%0d dn_r_req", i), dn_r_req, v.dnr);
            chk($sformatf("row%0d dn_w_req", i), dn_w_req, v.dnw);
            chk($sformatf("row%0d up_r_rdy", i), r_rdy, v.urrdy);
            chk($sformatf("row%0d up_w_rdy", i), w_rdy, v.uwrdy);
            chk($sformatf("row%0d up_re_valid", i), re_valid, v.urev);
            if (v.dnr) begin
                chk($sformatf("row%0d dn_r_addr", i), dn_r_addr, r_addr[v.ch*AW +: AW]);
                chk($sformatf("row%0d dn_r_type", i), dn_r_type, r_type[v.ch*TW +: TW]);
            end
            if (v.dnw) begin
                chk($sformatf("row%0d dn_w_addr", i), dn_w_addr, w_addr[v.ch*AW +: AW]);
                chk($sformatf("row%0d dn_w_data", i), dn_w_data, w_data[v.ch*DW +: DW]);
                chk($sformatf("row%0d dn_w_type", i), dn_w_type, w_type[v.ch*TW +: TW]);
                chk($sformatf("row%0d dn_w_strb", i), dn_w_strb, w_strb[v.ch*SW +: SW]);
            end
            if (v.urev != 0) chk($sformatf("row%0d up_re_data", i), re_data, {32{8'hA5}});
            step();
        end
        dn_re_valid = 0; dn_w_rdy = 0;

        // complete ch1 read (ptr 2), then reset while ch3 read is in RD_DATA
        r_req = 4'b0010; step();
        dn_r_rdy = 1; step();
        r_req = '0; dn_r_rdy = 0; dn_re_valid = 1; step();
        dn_re_valid = 0; r_req = 4'b1000; step();
        dn_r_rdy = 1; step();
        r_req = '0; dn_r_rdy = 0;
        #1;
        chk("pre-rst busy", busy, 1);
        #2 rst_n = 1'b0;
        dn_re_valid = 1;
        #1;
        chk("async rst busy", busy, 0);
        chk("async rst up_re_valid", re_valid, 0);
        chk("async rst up_re_data", re_data, 0);
        chk("async rst dn_r_addr", dn_r_addr, 0);
        step();
        chk("held rst up_re_valid", re_valid, 0);
        #2 rst_n = 1'b1;
        dn_re_valid = 0;
        step();
        r_req = 4'b1010; dn_re_valid = 1;
        #1;
        chk("post-rst idle busy", busy, 0);
        chk("post-rst stale up_re_valid", re_valid, 0);
        step();
        dn_re_valid = 0; dn_r_rdy = 1;
        #1;
        chk("post-rst dn_r_req", dn_r_req, 1);
        chk("post-rst grant ch1 addr", dn_r_addr, r_addr[1*AW +: AW]);
        chk("post-rst up_r_rdy", r_rdy, 4'b0010);
        step();
        r_req = '0; dn_r_rdy = 0; dn_re_valid = 1;
        #1;
        chk("post-rst up_re_valid", re_valid, 4'b0010);
        step();
        dn_re_valid = 0;

        // reads first: ch0 read served before ch1 write
        r_req_b = 4'b0001; w_req_b = 4'b0010; step();
        dn_r_rdy_b = 1;
        #1;
        chk("rdfirst dn_r_req", dn_r_req_b, 1);
        chk("rdfirst dn_w_req", dn_w_req_b, 0);
        chk("rdfirst dn_r_addr", dn_r_addr_b, r_addr[0 +: AW]);
        chk("rdfirst up_r_rdy", r_rdy_b, 4'b0001);
        step();
        r_req_b = '0; dn_r_rdy_b = 0; dn_re_valid_b = 1;
        #1;
        chk("rdfirst up_re_valid", re_valid_b, 4'b0001);
        step();
        dn_re_valid_b = 0; step();
        dn_w_rdy_b = 1;
        #1;
        chk("rdfirst then dn_w_req", dn_w_req_b, 1);
        chk("rdfirst then dn_w_addr", dn_w_addr_b, w_addr[1*AW +: AW]);
        chk("rdfirst then up_w_rdy", w_rdy_b, 4'b0010);
        step();
        w_req_b = '0; dn_w_rdy_b = 0;

        // 8 channels: ch7 then wrap to ptr 0
        w_req_c = 8'h80; step();
        dn_w_rdy_c = 1;
        #1;
        chk("wrap ch7 dn_w_addr", dn_w_addr_c, w_addr_c[7*32 +: 32]);
        chk("wrap ch7 dn_w_data", dn_w_data_c, w_data_c[7*32 +: 32]);
        chk("wrap ch7 up_w_rdy", w_rdy_c, 8'h80);
        step();
        dn_w_rdy_c = 0; w_req_c = 8'h81; step();
        #1;
        chk("wrap ch0 dn_w_req", dn_w_req_c, 1);
        chk("wrap ch0 dn_w_addr", dn_w_addr_c, w_addr_c[0 +: 32]);
        chk("wrap ch0 no early rdy", w_rdy_c, 8'h00);
        dn_w_rdy_c = 1;
        #1;
        chk("wrap ch0 up_w_rdy", w_rdy_c, 8'h01);
        step();
        dn_w_rdy_c = 0; w_req_c = '0;
        #1;
        chk("wrap idle busy", busy_c, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
